// File: rtl/tmf_sequencer.sv
// rtl/tmf_sequencer.sv - control FSM for the time-multiplexed FIR filter
// Sequences delay-line init, sample fetch/write, the shared MAC sweep and the run counter.
module tmf_sequencer #(
  parameter int NTAPS = 8,
  parameter int AW    = $clog2(NTAPS),
  parameter int LAT   = 1,
  parameter int NSAMP = 128,
  parameter int CW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  output logic          xSEL,
  output logic          xWE,
  output logic          zSel,
  output logic [AW-1:0] wAddr,
  output logic [AW-1:0] rdAddr,
  output logic [AW-1:0] cAddr,
  output logic          macClr,
  output logic          macEn,
  output logic          yValid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sampCnt
);

  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_MAC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_lat;
  logic [CW-1:0] r_samp_cnt;
  logic          r_done;

  logic          w_k_last;
  logic          w_lat_last;
  logic [CW:0]   w_cnt_inc;
  logic          w_hit;
  logic          w_done_next;

  assign w_k_last    = (r_k == AW'(NTAPS - 1));
  assign w_lat_last  = (r_lat == LW'(LAT - 1));
  // One extra bit so the terminal-count compare is immune to saturation.
  assign w_cnt_inc   = {1'b0, r_samp_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_hit       = (w_cnt_inc == (CW + 1)'(NSAMP));
  assign w_done_next = r_done | w_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (w_k_last) w_next = S_IDLE;
      S_IDLE:  if (EN && !r_done) w_next = S_LOAD;
      S_LOAD:  w_next = S_WRITE;
      S_WRITE: w_next = S_MAC;
      S_MAC:   if (w_k_last) w_next = (LAT == 0) ? S_OUT : S_DRAIN;
      S_DRAIN: if (w_lat_last) w_next = S_OUT;
      S_OUT:   w_next = (EN && !w_done_next) ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_k        <= '0;
      r_wr_ptr   <= '0;
      r_lat      <= '0;
      r_samp_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_INIT:  r_k <= r_k + AW'(1);
        S_WRITE: r_k <= '0;
        S_MAC: begin
          r_k   <= r_k + AW'(1);
          r_lat <= '0;
        end
        S_DRAIN: r_lat <= r_lat + LW'(1);
        S_OUT: begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          if (r_samp_cnt != {CW{1'b1}}) r_samp_cnt <= w_cnt_inc[CW-1:0];
          if (w_hit) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Newest sample sits at wrPtr, so tap k reads k samples back.
  assign xSEL    = (r_state == S_LOAD);
  assign xWE     = (r_state == S_INIT) || (r_state == S_WRITE);
  assign zSel    = (r_state == S_INIT);
  assign wAddr   = (r_state == S_INIT) ? r_k : r_wr_ptr;
  assign rdAddr  = (r_state == S_MAC) ? (r_wr_ptr - r_k) : '0;
  assign cAddr   = (r_state == S_MAC) ? r_k : '0;
  assign macClr  = (r_state == S_WRITE);
  assign macEn   = (r_state == S_MAC);
  assign yValid  = (r_state == S_OUT);
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign sampCnt = r_samp_cnt;

endmodule

// File: tb/tb_tmf_sequencer.sv
// tb/tb_tmf_sequencer.sv - scoreboard bench for tmf_sequencer
module tb_tmf_sequencer;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        xSEL, xWE, zSel, macClr, macEn, yValid, busy, done;
  logic [2:0]  wAddr, rdAddr, cAddr;
  logic [15:0] sampCnt;

  logic        rst_b, en_b;
  logic        xSEL_b, xWE_b, zSel_b, macClr_b, macEn_b, yValid_b, busy_b, done_b;
  logic [2:0]  wAddr_b, rdAddr_b, cAddr_b;
  logic [15:0] sampCnt_b;

  tmf_sequencer #(.NTAPS(8), .LAT(1), .NSAMP(128), .CW(16)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .xSEL(xSEL), .xWE(xWE), .zSel(zSel), .wAddr(wAddr), .rdAddr(rdAddr),
    .cAddr(cAddr), .macClr(macClr), .macEn(macEn), .yValid(yValid),
    .busy(busy), .done(done), .sampCnt(sampCnt)
  );

  tmf_sequencer #(.NTAPS(8), .LAT(1), .NSAMP(3), .CW(16)) u_dut_b (
    .CLK(CLK), .RST(rst_b), .EN(en_b),
    .xSEL(xSEL_b), .xWE(xWE_b), .zSel(zSel_b), .wAddr(wAddr_b), .rdAddr(rdAddr_b),
    .cAddr(cAddr_b), .macClr(macClr_b), .macEn(macEn_b), .yValid(yValid_b),
    .busy(busy_b), .done(done_b), .sampCnt(sampCnt_b)
  );

  always #5 CLK = ~CLK;

  // kind: 0 init write, 1 load, 2 write, 3 mac, 4 yvalid; off = cycles since xSEL, -1 = don't care
  typedef struct {
    int kind;
    int a;
    int b;
    int off;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mute   = 1'b1;
  int  mon_off = 0;
  int  yv_cnt = 0;
  int  xs_cnt = 0;
  bit  yv_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int a, input int b, input int off);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.off = off;
    q.push_back(e);
  endtask

  task automatic push_init();
    for (int k = 0; k < 8; k++) push(0, k, 0, -1);
  endtask

  task automatic push_frame(input int wp, input int cnt);
    push(1, 0, 0, 0);
    push(2, wp, 1, 1);
    for (int k = 0; k < 8; k++) push(3, k, (wp - k) & 7, 2 + k);
    push(4, cnt, 0, 11);
  endtask

  task automatic ev_check(input int kind, input int a, input int b);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_a", a, e.a);
      chk("event_b", b, e.b);
      if (e.off >= 0) chk("event_offset", mon_off, e.off);
    end
  endtask

  always @(negedge CLK) begin
    if (xSEL) mon_off = 0;
    else mon_off = mon_off + 1;
    if (!mute) begin
      if (macEn && macClr) chk("macen_macclr_overlap", 1, 0);
      if (xWE && zSel) ev_check(0, int'(wAddr), int'(macClr));
      if (xSEL) ev_check(1, 0, 0);
      if (xWE && !zSel) ev_check(2, int'(wAddr), int'(macClr));
      if (macEn) ev_check(3, int'(cAddr), int'(rdAddr));
      if (yValid) ev_check(4, int'(sampCnt), 0);
    end
  end

  always @(negedge CLK) begin
    if (!rst_b) begin
      if (yv_prev) chk("b_done_after_out", int'(done_b), (yv_cnt == 3) ? 1 : 0);
      yv_prev = yValid_b;
      if (yValid_b) yv_cnt++;
      if (xSEL_b) xs_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    CLK = 1'b0; RST = 1'b1; EN = 1'b0; rst_b = 1'b1; en_b = 1'b0;
    tick(3);
    push_init();
    RST = 1'b0;
    mute = 1'b0;
    chk("reset_busy", int'(busy), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_sampcnt", int'(sampCnt), 0);
    chk("reset_yvalid", int'(yValid), 0);
    tick(8);
    chk("idle_busy", int'(busy), 0);
    chk("idle_xwe", int'(xWE), 0);
    chk("idle_xsel", int'(xSEL), 0);
    chk("idle_macen", int'(macEn), 0);
    tick(2);

    push_frame(0, 0);
    EN = 1'b1;
    tick(1);
    EN = 1'b0;
    tick(14);
    chk("single_sampcnt", int'(sampCnt), 1);
    chk("single_busy", int'(busy), 0);

    for (int n = 1; n <= 9; n++) push_frame(n % 8, n);
    EN = 1'b1;
    tick(100);
    EN = 1'b0;
    tick(20);
    chk("burst_sampcnt", int'(sampCnt), 10);
    chk("burst_busy", int'(busy), 0);
    chk("burst_done", int'(done), 0);

    push(1, 0, 0, 0);
    push(2, 2, 1, 1);
    for (int k = 0; k < 4; k++) push(3, k, (2 - k) & 7, 2 + k);
    push_init();
    EN = 1'b1;
    tick(6);
    RST = 1'b1;
    EN = 1'b0;
    tick(1);
    RST = 1'b0;
    chk("midrst_yvalid", int'(yValid), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_sampcnt", int'(sampCnt), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_waddr", int'(wAddr), 0);
    tick(10);
    push_frame(0, 0);
    EN = 1'b1;
    tick(1);
    EN = 1'b0;
    tick(14);
    chk("postrst_sampcnt", int'(sampCnt), 1);
    chk("queue_drained", q.size(), 0);

    rst_b = 1'b0;
    tick(10);
    en_b = 1'b1;
    tick(60);
    chk("b_yvalid_count", yv_cnt, 3);
    chk("b_xsel_count", xs_cnt, 3);
    chk("b_done", int'(done_b), 1);
    chk("b_sampcnt", int'(sampCnt_b), 3);
    chk("b_busy", int'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmf_sequencer.md
Name: tmf_sequencer

Overview:
Control FSM for the time-multiplexed FIR filter. It pulls one input sample per frame from the input sample source via xSEL and writes it into a circular delay-line RAM. It then steps one shared MAC through all NTAPS coefficient/delay-line address pairs and flags each completed output. It owns delay-line initialisation after reset and a frame counter that stops the run after NSAMP outputs.

Parameters:
NTAPS, 8, filter tap count; must be a power of two, >= 2
AW, $clog2(NTAPS), width of delay-line and coefficient addresses
LAT, 1, datapath latency in cycles from address issue to accumulate (>= 0)
NSAMP, 128, number of output samples per run; done asserts after the last one
CW, 16, width of the sample counter

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
EN  in  1  run enable; sampled only in IDLE and OUT
xSEL  out  1  one-cycle fetch strobe to input sample source
xWE  out  1  delay-line write enable
zSel  out  1  1 = delay-line write data forced to zero (init), 0 = input sample
wAddr  out  AW  delay-line write address
rdAddr  out  AW  delay-line read address
cAddr  out  AW  coefficient ROM address
macClr  out  1  clear accumulator
macEn  out  1  accumulate enable, aligned with rdAddr/cAddr
yValid  out  1  one-cycle pulse: accumulator holds the completed output
busy  out  1  high in any state except IDLE
done  out  1  sticky, high after NSAMP outputs until RST
sampCnt  out  CW  outputs produced since reset

Behaviour:
- All state, counters and outputs are registered or decoded from registered state only. No combinational path from EN to any output.
- Reset (RST=1 at a clock edge): next cycle state=INIT, wrPtr=0, k=0, sampCnt=0, done=0. All strobes are 0 except those defined for INIT. RST takes priority in every state, including mid-frame; any partial frame is discarded and no yValid is produced.
- INIT (NTAPS cycles): xWE=1, zSel=1, wAddr=k, with k counting 0..NTAPS-1. After k=NTAPS-1 the FSM goes to IDLE and k=0.
- IDLE: busy=0. If EN=1 and done=0, go to LOAD; otherwise stay.
- LOAD (1 cycle): xSEL=1. The source presents its sample on the following cycle.
- WRITE (1 cycle): xWE=1, zSel=0, wAddr=wrPtr, macClr=1. Go to MAC with k=0.
- MAC (NTAPS cycles): macEn=1, cAddr=k, rdAddr=(wrPtr-k) mod NTAPS, using natural AW-bit wrap. After k=NTAPS-1 go to DRAIN, or to OUT if LAT=0.
- DRAIN (LAT cycles): all strobes 0; waits for the pipeline to finish.
- OUT (1 cycle): yValid=1. Updates on exit: wrPtr<=wrPtr+1 (wraps NTAPS-1 -> 0), sampCnt<=sampCnt+1, and done<=1 if sampCnt+1==NSAMP. Next state is LOAD if EN=1 and the updated done=0; otherwise IDLE.
- Frame length is NTAPS+LAT+3 cycles from LOAD entry to the end of OUT. Back-to-back frames have no gap.
- EN dropping mid-frame does not abort the frame. It completes through OUT, then goes to IDLE.
- Once done=1, EN is ignored; only RST restarts the run.
- xWE is never asserted outside INIT and WRITE. macEn and macClr are never high in the same cycle.
- sampCnt saturates at all-ones and never wraps.

Test Plan:
- Release RST with NTAPS=8 -> 8 cycles of xWE=1, zSel=1, wAddr 0..7, busy=1; then IDLE with busy=0 and all strobes 0.
- EN=1 for one frame, LAT=1, LOAD at cycle 0 -> xSEL@0; xWE@1 with wAddr=0 and macClr=1; macEn@2..9 with cAddr 0..7 and rdAddr 0,7,6,5,4,3,2,1; yValid@11; sampCnt=1.
- EN held high -> yValid every 12 cycles. Second frame writes wAddr=1 and reads rdAddr 1,0,7,...,2. Ninth frame wraps to wAddr=0.
- EN deasserted during MAC of frame 2 -> frame completes, yValid asserts, FSM returns to IDLE, no further xSEL.
- NSAMP=3 with EN held high -> exactly 3 yValid pulses, done=1 in the cycle after the third OUT, xSEL stays 0 afterwards, sampCnt=3.
- RST pulsed during the 4th MAC cycle -> next cycle: no yValid, done=0, sampCnt=0, INIT re-runs from wAddr=0; the next frame writes wAddr=0.
